// File: rtl/memory_utils_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | memory_utils_pkg : shared word type, fetch states, read-type constants   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package memory_utils_pkg;

  localparam int WORD_W = 12;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  localparam logic INSTRUCTION_FETCH = 1'b0;
  localparam logic DATA_READ         = 1'b1;

endpackage
`default_nettype wire

// File: rtl/fetch_pc_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_pc_reg : program counter with load / increment next-value mux      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fetch_pc_reg
  import memory_utils_pkg::*;
#(
  parameter word_t RESET_PC = 12'o0200
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  load_i,
  input  word_t load_value_i,
  input  logic  incr_i,
  output word_t pc_o
);

  word_t pc_q;
  word_t pc_d;

  // Load has priority; increment wraps naturally at 12 bits.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_value_i;
    end else if (incr_i) begin
      pc_d = pc_q + word_t'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_unit : instruction fetch FSM (IDLE/REQ/WAIT/HOLD) over memory ctrl |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fetch_unit
  import memory_utils_pkg::*;
#(
  parameter word_t RESET_PC = 12'o0200
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  run,
  input  logic  pc_load,
  input  word_t pc_load_value,
  input  logic  skip,
  input  logic  instr_ready,
  input  word_t mem_read_data,
  input  logic  mem_done,
  output word_t mem_address,
  output logic  mem_read_enable,
  output logic  mem_read_type,
  output logic  mem_write_enable,
  output word_t instr,
  output word_t instr_pc,
  output logic  instr_valid,
  output word_t pc
);

  fetch_state_e state_q;
  word_t        instr_q;
  word_t        instr_pc_q;
  logic         instr_valid_q;
  logic         rd_en_q;
  logic         pc_load_en;
  logic         pc_incr_en;
  word_t        pc_w;

  // PC only moves in IDLE (load), on fetch completion, and on HOLD hand-off.
  always_comb begin
    pc_load_en = 1'b0;
    pc_incr_en = 1'b0;
    case (state_q)
      IDLE: pc_load_en = pc_load;
      WAIT: pc_incr_en = mem_done;
      HOLD: begin
        pc_load_en = instr_ready & pc_load;
        pc_incr_en = instr_ready & skip;
      end
      default: ;
    endcase
  end

  fetch_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_i      (pc_load_en),
    .load_value_i(pc_load_value),
    .incr_i      (pc_incr_en),
    .pc_o        (pc_w)
  );

  // Read enable is set on entry to REQ so it is high for exactly that cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      rd_en_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!pc_load && run) begin
            state_q <= REQ;
            rd_en_q <= 1'b1;
          end
        end
        REQ: begin
          rd_en_q <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (mem_done) begin
            instr_q       <= mem_read_data;
            instr_pc_q    <= pc_w;
            instr_valid_q <= 1'b1;
            state_q       <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid_q <= 1'b0;
            if (run) begin
              state_q <= REQ;
              rd_en_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          rd_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_address      = pc_w;
  assign mem_read_enable  = rd_en_q;
  assign mem_read_type    = INSTRUCTION_FETCH;
  assign mem_write_enable = 1'b0;
  assign instr            = instr_q;
  assign instr_pc         = instr_pc_q;
  assign instr_valid      = instr_valid_q;
  assign pc               = pc_w;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_unit : directed self-checking bench with 3-cycle memory model   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_fetch_unit;
  import memory_utils_pkg::*;

  logic  clk;
  logic  reset_n;
  logic  run;
  logic  pc_load;
  word_t pc_load_value;
  logic  skip;
  logic  instr_ready;
  word_t mem_read_data;
  logic  mem_done;
  word_t mem_address;
  logic  mem_read_enable;
  logic  mem_read_type;
  logic  mem_write_enable;
  word_t instr;
  word_t instr_pc;
  logic  instr_valid;
  word_t pc;

  word_t mem [4096];
  logic  mdl_done   = 1'b0;
  logic  mdl_busy   = 1'b0;
  word_t mdl_addr   = '0;
  logic  stray_done = 1'b0;
  int    n_checks   = 0;
  int    n_errors   = 0;
  int    rd_count   = 0;

  fetch_unit #(
    .RESET_PC(12'o0200)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .run             (run),
    .pc_load         (pc_load),
    .pc_load_value   (pc_load_value),
    .skip            (skip),
    .instr_ready     (instr_ready),
    .mem_read_data   (mem_read_data),
    .mem_done        (mem_done),
    .mem_address     (mem_address),
    .mem_read_enable (mem_read_enable),
    .mem_read_type   (mem_read_type),
    .mem_write_enable(mem_write_enable),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .pc              (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_done = mdl_done | stray_done;

  // Controller: REQ cycle, READ cycle, DONE cycle with data.
  always @(posedge clk) begin
    mdl_done <= 1'b0;
    if (mem_read_enable) begin
      mdl_addr <= mem_address;
      mdl_busy <= 1'b1;
    end else if (mdl_busy) begin
      mdl_done      <= 1'b1;
      mem_read_data <= mem[mdl_addr];
      mdl_busy      <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (mem_read_enable) rd_count = rd_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0o expected %0o", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!instr_valid && cyc < 10) begin
      tick();
      cyc = cyc + 1;
    end
  endtask

  // Accept the held instruction with the given load/skip and verify the next fetch.
  task automatic fetch_from_hold(input string tag, input logic ld, input word_t ldv,
                                 input logic sk, input word_t exp_addr);
    int    rc0;
    int    cyc;
    word_t nxt;
    rc0           = rd_count;
    instr_ready   = 1'b1;
    pc_load       = ld;
    pc_load_value = ldv;
    skip          = sk;
    tick();
    instr_ready = 1'b0;
    pc_load     = 1'b0;
    skip        = 1'b0;
    check({tag, "_rden"}, mem_read_enable, 1'b1);
    check({tag, "_addr"}, mem_address, exp_addr);
    wait_valid(cyc);
    check({tag, "_lat"}, cyc, 3);
    check({tag, "_ipc"}, instr_pc, exp_addr);
    check({tag, "_instr"}, instr, mem[exp_addr]);
    nxt = exp_addr + word_t'(1);
    check({tag, "_pc"}, pc, nxt);
    check({tag, "_nreads"}, rd_count - rc0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int rc0;
    for (int i = 0; i < 4096; i++) mem[i] = ~(word_t'(i));
    mem[12'o0200] = 12'o7402;

    reset_n = 1'b0; run = 1'b0; pc_load = 1'b0; pc_load_value = '0;
    skip = 1'b0; instr_ready = 1'b0;
    tick(); tick();
    check("rst_pc", pc, 12'o0200);
    check("rst_addr", mem_address, 12'o0200);
    check("rst_instr", instr, 12'o0000);
    check("rst_ipc", instr_pc, 12'o0000);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_rden", mem_read_enable, 1'b0);
    check("rst_wren", mem_write_enable, 1'b0);
    check("rd_type", mem_read_type, INSTRUCTION_FETCH);

    // First fetch from RESET_PC
    reset_n = 1'b1;
    tick();
    run = 1'b1;
    tick();
    check("f0_rden", mem_read_enable, 1'b1);
    check("f0_addr", mem_address, 12'o0200);
    tick();
    check("f0_rden_off", mem_read_enable, 1'b0);
    tick();
    check("f0_notyet", instr_valid, 1'b0);
    tick();
    check("f0_valid", instr_valid, 1'b1);
    check("f0_instr", instr, 12'o7402);
    check("f0_ipc", instr_pc, 12'o0200);
    check("f0_pc", pc, 12'o0201);
    check("f0_nreads", rd_count, 1);

    // Stall in HOLD; load/skip must be ignored without instr_ready
    rc0 = rd_count;
    pc_load = 1'b1; pc_load_value = 12'o0555; skip = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_stable", {instr_valid, instr, instr_pc}, {1'b1, 12'o7402, 12'o0200});
    end
    check("hold_pc", pc, 12'o0201);
    check("hold_noread", rd_count - rc0, 0);
    pc_load = 1'b0; skip = 1'b0;

    fetch_from_hold("ld0300", 1'b1, 12'o0300, 1'b0, 12'o0300);
    fetch_from_hold("skip", 1'b0, 12'o0000, 1'b1, 12'o0302);
    fetch_from_hold("ldwins", 1'b1, 12'o0400, 1'b1, 12'o0400);

    // run dropped in WAIT: fetch still completes, then back to IDLE
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("rdrop_rden", mem_read_enable, 1'b1);
    check("rdrop_addr", mem_address, 12'o0401);
    tick();
    run = 1'b0;
    wait_valid(cyc);
    check("rdrop_valid", instr_valid, 1'b1);
    check("rdrop_ipc", instr_pc, 12'o0401);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    rc0 = rd_count;
    repeat (6) tick();
    check("rdrop_noread", rd_count - rc0, 0);
    check("rdrop_idle", instr_valid, 1'b0);

    // Load 7777 in IDLE, fetch there, then wrap to 0000
    pc_load = 1'b1; pc_load_value = 12'o7777;
    tick();
    pc_load = 1'b0;
    check("ld_pc", pc, 12'o7777);
    run = 1'b1;
    tick();
    check("w_rden", mem_read_enable, 1'b1);
    check("w_addr", mem_address, 12'o7777);
    wait_valid(cyc);
    check("w_ipc", instr_pc, 12'o7777);
    check("w_pc", pc, 12'o0000);
    fetch_from_hold("wrap", 1'b0, 12'o0000, 1'b0, 12'o0000);

    // Reset pulse during WAIT
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    tick();
    reset_n = 1'b0;
    run = 1'b0;
    #1;
    check("wr_pc", pc, 12'o0200);
    check("wr_addr", mem_address, 12'o0200);
    check("wr_valid", instr_valid, 1'b0);
    check("wr_instr", {instr, instr_pc}, 24'o0);
    check("wr_rden", mem_read_enable, 1'b0);
    reset_n = 1'b1;
    rc0 = rd_count;
    tick();
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    repeat (3) tick();
    check("wr_ignore_valid", instr_valid, 1'b0);
    check("wr_ignore_pc", pc, 12'o0200);
    check("wr_noread", rd_count - rc0, 0);
    run = 1'b1;
    tick();
    check("wr_rden2", mem_read_enable, 1'b1);
    check("wr_addr2", mem_address, 12'o0200);
    wait_valid(cyc);
    check("wr_lat", cyc, 3);
    check("wr_instr2", instr, 12'o7402);
    run = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 12'o0200, PC value loaded on reset.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 run  input  1  high = keep fetching; sampled in IDLE.
REQ-005 pc_load  input  1  load PC from pc_load_value (jump or front-panel load).
REQ-006 pc_load_value  input  12  word; new PC.
REQ-007 skip  input  1  advance PC one extra word (skip instruction).
REQ-008 instr_ready  input  1  decode stage accepts instr.
REQ-009 mem_read_data  input  12  word from memory_controller read_data.
REQ-010 mem_done  input  1  memory_controller operation_done.
REQ-011 mem_address  output  12  word to memory_controller address.
REQ-012 mem_read_enable  output  1  one-cycle read request.
REQ-013 mem_read_type  output  1  always INSTRUCTION_FETCH.
REQ-014 mem_write_enable  output  1  constant 0.
REQ-015 instr  output  12  fetched instruction word.
REQ-016 instr_pc  output  12  address instr was fetched from.
REQ-017 instr_valid  output  1  instr/instr_pc valid until accepted.
REQ-018 pc  output  12  current program counter.

Function
REQ-019 FSM states SHALL be exactly IDLE, REQ, WAIT, HOLD.
REQ-020 IDLE: pc_load=1 -> pc<=pc_load_value, stay IDLE; else run=1 -> REQ; else stay IDLE.
REQ-021 REQ: mem_read_enable=1, mem_address=pc for exactly one cycle; next state WAIT unconditionally.
REQ-022 mem_read_enable SHALL be 0 in every state except REQ (the controller re-arms from IDLE, so a held request would double-read).
REQ-023 WAIT: mem_address holds pc; on mem_done=1 -> instr<=mem_read_data, instr_pc<=pc, pc<=pc+1 mod 4096, next HOLD.
REQ-024 mem_done outside WAIT SHALL be ignored.
REQ-025 HOLD: instr_valid=1; instr and instr_pc stable while instr_ready=0.
REQ-026 HOLD with instr_ready=1: pc_load=1 -> pc<=pc_load_value; else skip=1 -> pc<=pc+1 mod 4096; then run=1 -> REQ, else IDLE.
REQ-027 pc_load and skip together: pc_load wins.
REQ-028 pc_load/skip SHALL be ignored in REQ, WAIT, and HOLD without instr_ready.
REQ-029 run falling during REQ/WAIT: fetch completes, instruction is still presented in HOLD.
REQ-030 PC arithmetic 12-bit unsigned, 7777 + 1 = 0000, no carry out.
REQ-031 Latency: run sampled in IDLE at cycle N -> instr_valid=1 at cycle N+4 with a 3-cycle controller (REQ, ctrl READ, ctrl DONE).
REQ-032 Back-to-back throughput: one instruction per 4 cycles with instr_ready held high.

Reset
REQ-033 reset_n=0 SHALL immediately force state IDLE, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, mem_read_enable=0, mem_address=RESET_PC.
REQ-034 Reset mid-WAIT: pending fetch is abandoned; any mem_done arriving in IDLE after reset release is ignored.

Structure
REQ-035 Type word, the fetch state enum and the INSTRUCTION_FETCH/DATA_READ constants SHALL live in memory_utils.pkg.
REQ-036 The PC register and its next-value mux (load/skip/increment) SHALL be one sub-module, fetch_pc_reg; the FSM stays in fetch_unit.

Verification
REQ-037 Reset release, run=1, memory[0200]=7402 -> one mem_read_enable pulse at address 0200, then instr=7402, instr_pc=0200, instr_valid 4 cycles after run, pc=0201.
REQ-038 pc_load in IDLE with value 7777, run=1, instr_ready=1 -> fetch at 7777, then next fetch at 0000 (wrap).
REQ-039 HOLD, instr_ready=1, skip=1, pc=0301 -> next fetch at 0302; same with pc_load=1, value 0400 -> next fetch at 0400 (load wins).
REQ-040 instr_ready held 0 for 10 cycles in HOLD -> instr, instr_pc, instr_valid stable, no mem_read_enable.
REQ-041 run dropped in WAIT -> instruction still delivered, then FSM returns to IDLE with no further read.
REQ-042 reset_n pulsed low during WAIT -> outputs at reset values that same cycle, stray mem_done ignored, next fetch at RESET_PC.
